alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational 32-bit ALU.
- Same opcode set and N/Z/V/C/error outputs, plus:
  - generic WIDTH;
  - correctly defined flags for every opcode;
  - valid/ready handshakes on input and output;
  - an optional multi-cycle unsigned multiply.
- Sits between the operand-fetch stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand and result width (>= 4; power of 2).
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block accepts on in_valid && in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts on out_valid && out_ready
- s  out  WIDTH  result
- n  out  1  negative: s[WIDTH-1]
- z  out  1  zero: s == 0
- v  out  1  overflow (defined per op)
- c  out  1  carry (defined per op)
- err  out  1  illegal opcode

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid=0; s=0; n=z=v=c=err=0; multiplier cleared. in_ready=0 while rst is high.
- Opcodes, shifts by b[SHW-1:0]:
  - ADD 0000: s=a+b. c=carry out of bit WIDTH-1. v=signed overflow.
  - SUB 1000: s=a-b. c=1 when no borrow (a>=b unsigned). v=(a[W-1]!=b[W-1]) && (s[W-1]!=a[W-1]).
  - SLL 0001, SRL 0101: c=last bit shifted out (0 if amount=0). v=0.
  - SRA 1101: arithmetic right shift. c=last bit shifted out (0 if amount=0). v=0.
  - SLT 0010: s=($signed(a)<$signed(b)). c=v=0.
  - SLTU 0011: s=(a<b unsigned). c=v=0.
  - XOR 0100, OR 0110, AND 0111: c=v=0.
  - MUL 1001 (ALU_MUL_EN only): s=low WIDTH bits of a*b unsigned. v=c=(high WIDTH bits != 0).
- Illegal opcode: s=0, z=1, n=v=c=0, err=1. Completes as a normal 1-cycle op; never all-X.
- n and z are always computed from the registered s.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE: in_ready=1.
    - Accept single-cycle op: result registered on the same edge, HOLD, out_valid=1 next cycle (latency 1).
    - Accept MUL: operands latched, BUSY, counter=WIDTH-1.
  - BUSY: in_ready=0. One shift-add step per cycle. When counter=0, register result, go to HOLD. Accept-to-out_valid latency = WIDTH+1 cycles.
  - HOLD: out_valid=1; s and flags stable until handshake. in_ready=out_ready (pass-through).
    - out_ready=1 and in_valid=1: new op accepted on the same edge. Single-cycle op stays in HOLD with the new result (back-to-back throughput 1/cycle). MUL goes to BUSY, out_valid=0.
    - out_ready=1, in_valid=0: to IDLE, out_valid=0.
- Output stall: s and flags never change while out_valid && !out_ready.
- Changes to a/b/op while not accepted have no effect.
- rst mid-MUL: aborts immediately to reset values; no partial result appears.

Optional Feature:
- ALU_MUL_EN defined: MUL 1001 supported; multiplier sub-module instantiated; BUSY state reachable.
- ALU_MUL_EN undefined: 1001 is an illegal opcode (err=1, 1-cycle); no multiplier logic; BUSY unreachable.

Decomposition:
- alu_pkg holds:
  - opcode enum alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL);
  - packed struct alu_flags_t {n,z,v,c,err};
  - state enum alu_state_e {IDLE, BUSY, HOLD}.
- One sub-module, alu_seq_mul:
  - iterative WIDTH-cycle shift-add unsigned multiplier;
  - start/done handshake;
  - 2*WIDTH product;
  - instantiated only under ALU_MUL_EN.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1, out_ready=1 -> next cycle out_valid=1, s=0x80000000, n=1, v=1, c=0, z=0.
- SUB 5-5, then SUB 3-5 back-to-back -> s=0, z=1, c=1; then s=0xFFFFFFFE, n=1, c=0, v=0. Consecutive out_valid cycles.
- SRA 0x80000010 by b=4 -> s=0xF8000001, c=0. SLL 0xC0000000 by 1 -> s=0x80000000, c=1.
- Hold out_ready=0 for 5 cycles after XOR 0xFF00 ^ 0x0FF0 -> s=0xF0F0 stable, in_ready=0. Release: IDLE next cycle.
- op=1010 -> err=1, s=0, z=1. With ALU_MUL_EN: MUL 0x10000*0x10000 -> out_valid 33 cycles after accept, s=0, v=c=1. Without the macro: err=1 after 1 cycle.
- Assert rst during MUL cycle 10 -> out_valid=0, s=0, flags=0 immediately. Next ADD 2+3 -> s=5 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// alu_pkg: opcode, flag and state types shared by the pipelined ALU and its multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_MUL  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
    logic err;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
`timescale 1ns/1ps
// alu_seq_mul: iterative shift-add unsigned multiplier, one partial product per cycle.
// start latches operands; done pulses for one cycle once the 2*WIDTH product is final.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done_q;
  logic [WIDTH:0]   sum;

  // Multiplier bits are consumed from lo[0] while product bits shift in from the top.
  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign product = {hi, lo};
  assign done    = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand <= a;
        hi    <= '0;
        lo    <= b;
        cnt   <= CW'(WIDTH - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        {hi, lo} <= {sum, lo[WIDTH-1:1]};
        if (cnt == '0) begin
          busy   <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
// alu_pipe: registered ALU with valid/ready on both sides and N/Z/V/C/err flags.
// Define ALU_MUL_EN to add the multi-cycle unsigned multiply (opcode 1001).
//   state | meaning
//   IDLE  | nothing held, ready for a new op
//   BUSY  | multiplier iterating, input stalled
//   HOLD  | result and flags presented until the consumer takes them
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             c,
  output logic             err
);

  alu_state_e       state;
  alu_flags_t       flags_q;
  alu_flags_t       res_flags;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] res_s;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   sub_x;
  logic [WIDTH:0]   sll_x;
  logic [WIDTH:0]   srl_x;
  logic [WIDTH:0]   sra_x;
  logic             accept;
  logic             is_mul;

  assign amt = b[SHW-1:0];

  // Shifts carry one extra bit so the last bit shifted out lands in bit WIDTH or bit 0.
  always_comb begin
    add_x     = {1'b0, a} + {1'b0, b};
    sub_x     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sll_x     = {1'b0, a} << amt;
    srl_x     = {a, 1'b0} >> amt;
    sra_x     = $signed({a, 1'b0}) >>> amt;
    res_s     = '0;
    res_flags = '0;
    case (op)
      ALU_ADD: begin
        res_s       = add_x[WIDTH-1:0];
        res_flags.c = add_x[WIDTH];
        res_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_s       = sub_x[WIDTH-1:0];
        res_flags.c = sub_x[WIDTH];
        res_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLL: begin
        res_s       = sll_x[WIDTH-1:0];
        res_flags.c = sll_x[WIDTH];
      end
      ALU_SRL: begin
        res_s       = srl_x[WIDTH:1];
        res_flags.c = srl_x[0];
      end
      ALU_SRA: begin
        res_s       = sra_x[WIDTH:1];
        res_flags.c = sra_x[0];
      end
      ALU_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_XOR:  res_s = a ^ b;
      ALU_OR:   res_s = a | b;
      ALU_AND:  res_s = a & b;
`ifdef ALU_MUL_EN
      ALU_MUL:  ;
`endif
      default:  res_flags.err = 1'b1;
    endcase
    res_flags.n = res_s[WIDTH-1];
    res_flags.z = (res_s == '0);
  end

  assign in_ready  = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  assign s   = s_q;
  assign n   = flags_q.n;
  assign z   = flags_q.z;
  assign v   = flags_q.v;
  assign c   = flags_q.c;
  assign err = flags_q.err;

`ifdef ALU_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  alu_flags_t         mul_flags;

  assign is_mul = (op == ALU_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_p)
  );

  always_comb begin
    mul_flags     = '0;
    mul_flags.n   = mul_p[WIDTH-1];
    mul_flags.z   = (mul_p[WIDTH-1:0] == '0);
    mul_flags.v   = |mul_p[2*WIDTH-1:WIDTH];
    mul_flags.c   = |mul_p[2*WIDTH-1:WIDTH];
  end
`else
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_q     <= '0;
      flags_q <= '0;
    end else if (accept) begin
      if (is_mul) begin
        state <= BUSY;
      end else begin
        s_q     <= res_s;
        flags_q <= res_flags;
        state   <= HOLD;
      end
    end else begin
      case (state)
`ifdef ALU_MUL_EN
        BUSY: if (mul_done) begin
          s_q     <= mul_p[WIDTH-1:0];
          flags_q <= mul_flags;
          state   <= HOLD;
        end
`endif
        HOLD:    if (out_ready) state <= IDLE;
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
